// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a transmit FIFO.
// Registered bus read data is zero when the block is not selected.
module mmio_uart_tx #(
  parameter int unsigned CLOCK_FREQ   = 25000000,
  parameter int unsigned BIT_RATE     = 115200,
  parameter logic [31:0] BASE_ADDRESS = 32'h80000000,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CLOCK_FREQ / BIT_RATE - 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  state_t      state_next;

  logic        sel;
  logic [1:0]  off;
  logic        wr_en;
  logic        rd_en;
  logic        push;
  logic        push_ok;
  logic        pop;
  logic        full;
  logic        empty;
  logic        busy;
  logic        overflow;
  logic [15:0] baud_div;
  logic [31:0] rdata_next;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0] count;

  logic [7:0]  shift;
  logic [2:0]  bitcnt;
  logic [15:0] baudcnt;
  logic [15:0] period;
  logic        bit_end;

  logic        unused;
  assign unused = ^{address[1:0], write_data[31:16]};

  assign sel     = (address[31:4] == BASE_ADDRESS[31:4]);
  assign off     = address[3:2];
  assign wr_en   = memory_write && sel;
  assign rd_en   = memory_read && sel;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  assign push    = wr_en && (off == 2'd0);
  assign push_ok = push && !full;
  assign bit_end = (baudcnt == period);

  // FIFO storage; contents need no reset, pointers decide validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= write_data[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push_ok && !pop) count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  // Register read mux, sampled before any write in the same cycle
  always_comb begin
    rdata_next = '0;
    if (rd_en) begin
      unique case (off)
        2'd1: rdata_next = {28'b0, overflow, busy, empty, full};
        2'd2: rdata_next = {16'b0, baud_div};
        default: rdata_next = '0;
      endcase
    end
  end

  // Control registers and registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      baud_div  <= DIV_RST;
      read_data <= '0;
    end else begin
      read_data <= rdata_next;
      if (push && full) overflow <= 1'b1;
      else if (wr_en && off == 2'd1 && write_data[3]) overflow <= 1'b0;
      if (wr_en && off == 2'd2) baud_div <= write_data[15:0];
    end
  end

  // Serialiser state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  // Serialiser next state, FIFO pop and line level
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx         = 1'b1;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (bit_end && bitcnt == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register, bit and baud counters; period latched per frame
  always_ff @(posedge clk) begin
    if (reset) begin
      shift   <= '0;
      bitcnt  <= '0;
      baudcnt <= '0;
      period  <= DIV_RST;
    end else if (pop) begin
      shift   <= mem[rptr];
      bitcnt  <= '0;
      baudcnt <= '0;
      period  <= baud_div;
    end else if (state != IDLE) begin
      if (bit_end) begin
        baudcnt <= '0;
        if (state == DATA) begin
          shift  <= {1'b0, shift[7:1]};
          bitcnt <= bitcnt + 1'b1;
        end
      end else begin
        baudcnt <= baudcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic
// against a timeline model of the FIFO, registers and tx line.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        tx;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q[$];
  bit          ovf;
  int          baud;
  int          npe;
  int          e0;
  int          per;
  bit [7:0]    cur;
  bit          fv;
  int          ecount;
  logic [31:0] exp_rd;
  logic        exp_tx;

  localparam logic [31:0] BASE = 32'h80000000;

  mmio_uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .memory_read  (memory_read),
    .memory_write (memory_write),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not end, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)",
               tag, got, want, ecount);
    end
  endtask

  function automatic logic [31:0] reg_val(input logic [1:0] o);
    logic [31:0] v;
    v = '0;
    if (o == 2'd1) begin
      v[0] = (q.size() == 8);
      v[1] = (q.size() == 0);
      v[2] = (ecount < npe);
      v[3] = ovf;
    end else if (o == 2'd2) begin
      v = 32'(baud);
    end
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs seen at it.
  task automatic model_edge(input logic rst, input logic rd,
                            input logic wr, input logic [31:0] a,
                            input logic [31:0] d);
    bit s;
    bit full_pre;
    int c;
    int idx;
    ecount++;
    s = (a[31:4] == BASE[31:4]);
    if (rst) begin
      exp_rd = '0;
      q.delete();
      ovf  = 0;
      baud = 216;
      fv   = 0;
      npe  = ecount + 1;
    end else begin
      exp_rd = (rd && s) ? reg_val(a[3:2]) : 32'h0;
      full_pre = (q.size() == 8);
      if (ecount >= npe && q.size() > 0) begin
        cur = q.pop_front();
        e0  = ecount;
        per = baud + 1;
        npe = ecount + 10 * per + 1;
        fv  = 1;
      end
      if (wr && s) begin
        case (a[3:2])
          2'd0: if (full_pre) ovf = 1; else q.push_back(d[7:0]);
          2'd1: if (d[3]) ovf = 0;
          2'd2: baud = int'(d[15:0]);
          default: ;
        endcase
      end
    end
    c = ecount + 1;
    exp_tx = 1'b1;
    if (fv && c >= e0 + 1 && c <= e0 + 10 * per) begin
      idx = (c - e0 - 1) / per;
      if (idx == 0) exp_tx = 1'b0;
      else if (idx <= 8) exp_tx = cur[idx-1];
    end
  endtask

  task automatic cyc(input logic rst, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    reset        = rst;
    memory_read  = rd;
    memory_write = wr;
    address      = a;
    write_data   = d;
    @(posedge clk);
    model_edge(rst, rd, wr, a, d);
    #1;
    check("read_data", read_data, exp_rd);
    check("tx", {31'b0, tx}, {31'b0, exp_tx});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 0, 1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(0, 1, 0, a, 32'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || ecount <= npe) && n < 3000) begin
      idle(1);
      n++;
    end
    check("drain_left", 32'(q.size()), 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int op;
    ecount = 0;
    npe = 0;
    fv = 0;
    baud = 216;
    reset = 1'b1;
    memory_read = 1'b0;
    memory_write = 1'b0;
    address = '0;
    write_data = '0;
    @(posedge clk);
    cyc(1, 0, 0, 32'h0, 32'h0);

    rd(BASE + 32'h4);
    check("rst_status", read_data, 32'h2);
    idle(1);
    check("rd_cleared", read_data, 32'h0);
    rd(BASE + 32'h8);
    check("rst_baud", read_data, 32'd216);

    wr(BASE + 32'h8, 32'h3);
    wr(BASE + 32'h0, 32'h55);
    idle(1);
    check("tx_start_lat", {31'b0, tx}, 32'h0);
    rd(BASE + 32'h4);
    idle(1);
    rd(BASE + 32'h4);
    drain();
    rd(BASE + 32'h4);
    check("idle_status", read_data, 32'h2);

    wr(BASE + 32'h8, 32'h0);
    for (int i = 1; i <= 10; i++) wr(BASE, 32'(i));
    rd(BASE + 32'h4);
    check("ovf_full", read_data & 32'h9, 32'h9);
    wr(BASE + 32'h4, 32'h8);
    rd(BASE + 32'h4);
    check("ovf_clr", read_data & 32'h8, 32'h0);
    drain();

    wr(BASE + 32'h8, 32'h2);
    wr(BASE, 32'hA5);
    wr(BASE, 32'h11);
    wr(BASE, 32'h22);
    idle(9);
    cyc(1, 1, 1, BASE, 32'h77);
    check("rst_tx", {31'b0, tx}, 32'h1);
    rd(BASE + 32'h4);
    check("rst_mid_status", read_data, 32'h2);
    idle(60);

    cyc(0, 1, 1, 32'h80000010, 32'h41);
    cyc(0, 1, 1, 32'h00000004, 32'h8);
    cyc(0, 1, 1, 32'h00000000, 32'h42);
    cyc(0, 1, 1, BASE + 32'hC, 32'hFFFF_FFFF);
    check("rsvd_rd", read_data, 32'h0);
    rd(BASE + 32'h4);
    check("outside_status", read_data, 32'h2);
    idle(5);

    wr(BASE + 32'h8, 32'h1);
    wr(BASE, 32'h3C);
    wr(BASE, 32'hC3);
    idle(3);
    wr(BASE + 32'h8, 32'hABCD_0007);
    rd(BASE + 32'h8);
    check("baud_upper", read_data, 32'h7);
    drain();

    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 11);
      a = BASE | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      case (op)
        0, 1, 2, 3: wr(BASE | 32'($urandom_range(0, 3)), d);
        4: rd(BASE + 32'h4);
        5: wr(BASE + 32'h8, (d & 32'hFFFF_0000) | 32'($urandom_range(0, 3)));
        6: cyc(0, $urandom_range(0, 1), 1, BASE + 32'h4, d);
        7: cyc(0, 1, $urandom_range(0, 1), a,
               (a[3:2] == 2'd2) ? 32'($urandom_range(0, 3)) : d);
        8: cyc(0, $urandom_range(0, 1), $urandom_range(0, 1),
               {$urandom} | 32'h0000_0010 ^ BASE, d);
        9: idle($urandom_range(1, 30));
        10: cyc(($urandom_range(0, 40) == 0), $urandom_range(0, 1),
                $urandom_range(0, 1), a, d & 32'h0000_00FF);
        default: idle(1);
      endcase
    end
    drain();
    rd(BASE + 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
